// File: rtl/buffer_ram_tfsize_if.sv
// Port bundle for the (I)NTT buffer block: twiddle RAM A, 2R2W coefficient RAM B
// and the fixed-latency delay line carried alongside the butterfly pipeline.
interface buffer_ram_tfsize_if #(
   parameter int FSIZE     = 64,
   parameter int AW        = 12,
   parameter int DLY_WIDTH = 12
);
   logic [AW-1:0]        a_raddr;
   logic [FSIZE-1:0]     a_rdata;
   logic [AW-1:0]        a_waddr;
   logic [FSIZE-1:0]     a_wdata;
   logic                 a_wren;
   logic [AW-1:0]        b_raddr0;
   logic [AW-1:0]        b_raddr1;
   logic [FSIZE-1:0]     b_rdata0;
   logic [FSIZE-1:0]     b_rdata1;
   logic [AW-1:0]        b_waddr0;
   logic [FSIZE-1:0]     b_wdata0;
   logic                 b_wren0;
   logic [AW-1:0]        b_waddr1;
   logic [FSIZE-1:0]     b_wdata1;
   logic                 b_wren1;
   logic [DLY_WIDTH-1:0] d_in;
   logic [DLY_WIDTH-1:0] d_out;

   modport master (
      output a_raddr, a_waddr, a_wdata, a_wren,
      output b_raddr0, b_raddr1, b_waddr0, b_wdata0, b_wren0, b_waddr1, b_wdata1, b_wren1,
      output d_in,
      input  a_rdata, b_rdata0, b_rdata1, d_out
   );

   modport slave (
      input  a_raddr, a_waddr, a_wdata, a_wren,
      input  b_raddr0, b_raddr1, b_waddr0, b_wdata0, b_wren0, b_waddr1, b_wdata1, b_wren1,
      input  d_in,
      output a_rdata, b_rdata0, b_rdata1, d_out
   );
endinterface

// File: rtl/buffer_ram_tfsize.sv
// Twiddle RAM (1R1W), coefficient RAM (2R2W) and delay line with fixed latencies,
// so the (I)NTT controller can schedule everything statically.
module buffer_ram_tfsize #(
   parameter int FSIZE        = 64,
   parameter int DEPTH        = 4096,
   parameter int READ_LATENCY = 1,
   parameter int DLY_WIDTH    = 12,
   parameter int DLY_CYCLES   = 8,
   parameter int ID           = 0
) (
   input logic                clk,
   input logic                rstn,
   buffer_ram_tfsize_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   generate
      if (DEPTH != (1 << AW) || READ_LATENCY < 1 || DLY_CYCLES < 1 || ID < 0) begin : g_param_err
         $error("buffer_ram_tfsize: illegal parameter set");
      end
   endgenerate

   logic [FSIZE-1:0] mem_a [DEPTH];
   logic [FSIZE-1:0] mem_b [DEPTH];

   // Storage is never reset; writes are simply suppressed while rstn is low.
   always_ff @(posedge clk) begin
      if (rstn && bus.a_wren) mem_a[bus.a_waddr] <= bus.a_wdata;
   end

   // Port 1 is assigned last so it overrides port 0 on an address collision.
   always_ff @(posedge clk) begin
      if (rstn) begin
         if (bus.b_wren0) mem_b[bus.b_waddr0] <= bus.b_wdata0;
         if (bus.b_wren1) mem_b[bus.b_waddr1] <= bus.b_wdata1;
      end
   end

   // Lanes: [0] RAM A, [1] RAM B port 0, [2] RAM B port 1. Stage 0 samples the
   // arrays before this edge's writes land, which gives read-first behaviour.
   logic [READ_LATENCY-1:0][2:0][FSIZE-1:0] rd_pipe;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= {mem_b[bus.b_raddr1], mem_b[bus.b_raddr0], mem_a[bus.a_raddr]};
         for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   assign bus.a_rdata  = rd_pipe[READ_LATENCY-1][0];
   assign bus.b_rdata0 = rd_pipe[READ_LATENCY-1][1];
   assign bus.b_rdata1 = rd_pipe[READ_LATENCY-1][2];

   logic [DLY_CYCLES-1:0][DLY_WIDTH-1:0] dly;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         dly <= '0;
      end else begin
         dly[0] <= bus.d_in;
         for (int i = 1; i < DLY_CYCLES; i++) dly[i] <= dly[i-1];
      end
   end

   assign bus.d_out = dly[DLY_CYCLES-1];
endmodule

// File: tb/tb_buffer_ram_tfsize.sv
// Scoreboard bench for buffer_ram_tfsize: expected read/delay values are queued
// when stimulus is driven and popped when the fixed latency has elapsed.
module tb_buffer_ram_tfsize;
   localparam int FSIZE = 64;
   localparam int DEPTH = 4096;
   localparam int RL    = 1;
   localparam int DW    = 12;
   localparam int DLY   = 8;
   localparam int AW    = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [FSIZE-1:0] qa[$];
   logic [FSIZE-1:0] qb0[$];
   logic [FSIZE-1:0] qb1[$];
   logic [DW-1:0]    qd[$];

   buffer_ram_tfsize_if #(.FSIZE(FSIZE), .AW(AW), .DLY_WIDTH(DW)) bus ();

   buffer_ram_tfsize #(
      .FSIZE(FSIZE), .DEPTH(DEPTH), .READ_LATENCY(RL),
      .DLY_WIDTH(DW), .DLY_CYCLES(DLY), .ID(0)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.a_raddr = '0; bus.a_waddr = '0; bus.a_wdata = '0; bus.a_wren = 1'b0;
      bus.b_raddr0 = '0; bus.b_raddr1 = '0;
      bus.b_waddr0 = '0; bus.b_wdata0 = '0; bus.b_wren0 = 1'b0;
      bus.b_waddr1 = '0; bus.b_wdata1 = '0; bus.b_wren1 = 1'b0;
      bus.d_in = '0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) tick();
      n_cmp += 4;
      if (bus.a_rdata !== '0)  begin n_err++; $display("FAIL reset_a_rdata: got %h want 0", bus.a_rdata); end
      if (bus.b_rdata0 !== '0) begin n_err++; $display("FAIL reset_b_rdata0: got %h want 0", bus.b_rdata0); end
      if (bus.b_rdata1 !== '0) begin n_err++; $display("FAIL reset_b_rdata1: got %h want 0", bus.b_rdata1); end
      if (bus.d_out !== '0)    begin n_err++; $display("FAIL reset_d_out: got %h want 0", bus.d_out); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_ram_a_fill();
      logic [FSIZE-1:0] e;
      for (int a = 0; a < DEPTH; a++) begin
         bus.a_waddr = AW'(a);
         bus.a_wdata = FSIZE'(a * 3 + 1);
         bus.a_wren  = 1'b1;
         tick();
      end
      bus.a_wren = 1'b0;
      for (int i = 0; i < DEPTH + RL - 1; i++) begin
         if (i < DEPTH) begin
            bus.a_raddr = AW'(i);
            qa.push_back(FSIZE'(i * 3 + 1));
         end
         tick();
         if (i >= RL - 1) begin
            e = qa.pop_front();
            n_cmp++;
            if (bus.a_rdata !== e) begin
               n_err++;
               $display("FAIL ram_a_readback[%0d]: got %h want %h", i - RL + 1, bus.a_rdata, e);
            end
         end
      end
   endtask

   task automatic test_ram_b_dual();
      logic [FSIZE-1:0] e0, e1;
      bus.b_waddr0 = AW'(5); bus.b_wdata0 = 64'h11; bus.b_wren0 = 1'b1;
      bus.b_waddr1 = AW'(9); bus.b_wdata1 = 64'h22; bus.b_wren1 = 1'b1;
      tick();
      bus.b_wren0 = 1'b0; bus.b_wren1 = 1'b0;
      bus.b_raddr0 = AW'(9); bus.b_raddr1 = AW'(5);
      qb0.push_back(64'h22); qb1.push_back(64'h11);
      repeat (RL) tick();
      e0 = qb0.pop_front(); e1 = qb1.pop_front();
      n_cmp += 2;
      if (bus.b_rdata0 !== e0) begin n_err++; $display("FAIL ram_b_dual_rdata0: got %h want %h", bus.b_rdata0, e0); end
      if (bus.b_rdata1 !== e1) begin n_err++; $display("FAIL ram_b_dual_rdata1: got %h want %h", bus.b_rdata1, e1); end
   endtask

   task automatic test_ram_b_collision();
      logic [FSIZE-1:0] e0, e1;
      bus.b_waddr0 = AW'(7); bus.b_wdata0 = 64'hAA; bus.b_wren0 = 1'b1;
      bus.b_waddr1 = AW'(7); bus.b_wdata1 = 64'hBB; bus.b_wren1 = 1'b1;
      tick();
      bus.b_wren0 = 1'b0; bus.b_wren1 = 1'b0;
      bus.b_raddr0 = AW'(7); bus.b_raddr1 = AW'(7);
      qb0.push_back(64'hBB); qb1.push_back(64'hBB);
      repeat (RL) tick();
      e0 = qb0.pop_front(); e1 = qb1.pop_front();
      n_cmp += 2;
      if (bus.b_rdata0 !== e0) begin n_err++; $display("FAIL ram_b_collision_rdata0: got %h want %h", bus.b_rdata0, e0); end
      if (bus.b_rdata1 !== e1) begin n_err++; $display("FAIL ram_b_collision_rdata1: got %h want %h", bus.b_rdata1, e1); end
   endtask

   task automatic test_read_during_write();
      logic [FSIZE-1:0] e;
      bus.a_waddr = AW'(3); bus.a_wdata = 64'h5; bus.a_wren = 1'b1;
      tick();
      for (int i = 0; i <= RL; i++) begin
         if (i == 0) begin
            bus.a_waddr = AW'(3); bus.a_wdata = 64'h6; bus.a_wren = 1'b1;
            bus.a_raddr = AW'(3);
            qa.push_back(64'h5);
         end else if (i == 1) begin
            bus.a_wren = 1'b0;
            bus.a_raddr = AW'(3);
            qa.push_back(64'h6);
         end
         tick();
         if (i >= RL - 1) begin
            e = qa.pop_front();
            n_cmp++;
            if (bus.a_rdata !== e) begin
               n_err++;
               $display("FAIL read_during_write[%0d]: got %h want %h", i - RL + 1, bus.a_rdata, e);
            end
         end
      end
      bus.a_wren = 1'b0;
   endtask

   task automatic test_write_in_reset();
      logic [FSIZE-1:0] e;
      bus.a_waddr = AW'(10); bus.a_wdata = 64'h1234; bus.a_wren = 1'b1;
      tick();
      rstn = 1'b0;
      bus.a_wdata = 64'hDEAD;
      bus.b_waddr0 = AW'(5); bus.b_wdata0 = 64'hDEAD; bus.b_wren0 = 1'b1;
      repeat (2) tick();
      rstn = 1'b1;
      bus.a_wren = 1'b0; bus.b_wren0 = 1'b0;
      bus.a_raddr = AW'(10); bus.b_raddr0 = AW'(5);
      qa.push_back(64'h1234); qb0.push_back(64'h11);
      repeat (RL) tick();
      n_cmp += 2;
      e = qa.pop_front();
      if (bus.a_rdata !== e) begin n_err++; $display("FAIL write_in_reset_a: got %h want %h", bus.a_rdata, e); end
      e = qb0.pop_front();
      if (bus.b_rdata0 !== e) begin n_err++; $display("FAIL write_in_reset_b: got %h want %h", bus.b_rdata0, e); end
   endtask

   task automatic test_reset_flush();
      logic [DW-1:0] e;
      bus.a_raddr = AW'(3);
      bus.b_raddr0 = AW'(9); bus.b_raddr1 = AW'(5);
      bus.d_in = 12'hABC;
      repeat (20) tick();
      for (int j = 0; j <= DLY + 3; j++) begin
         rstn = (j == 0) ? 1'b0 : 1'b1;
         qd.push_back((j < DLY) ? 12'h000 : 12'hABC);
         tick();
         e = qd.pop_front();
         n_cmp++;
         if (bus.d_out !== e) begin
            n_err++;
            $display("FAIL reset_flush_d_out[%0d]: got %h want %h", j, bus.d_out, e);
         end
         if (j == 0) begin
            n_cmp += 3;
            if (bus.a_rdata !== '0)  begin n_err++; $display("FAIL flush_a_rdata: got %h want 0", bus.a_rdata); end
            if (bus.b_rdata0 !== '0) begin n_err++; $display("FAIL flush_b_rdata0: got %h want 0", bus.b_rdata0); end
            if (bus.b_rdata1 !== '0) begin n_err++; $display("FAIL flush_b_rdata1: got %h want 0", bus.b_rdata1); end
         end
         if (j == RL) begin
            n_cmp += 3;
            if (bus.a_rdata !== 64'h6)   begin n_err++; $display("FAIL flush_recover_a: got %h want 6", bus.a_rdata); end
            if (bus.b_rdata0 !== 64'h22) begin n_err++; $display("FAIL flush_recover_b0: got %h want 22", bus.b_rdata0); end
            if (bus.b_rdata1 !== 64'h11) begin n_err++; $display("FAIL flush_recover_b1: got %h want 11", bus.b_rdata1); end
         end
      end
   endtask

   task automatic test_delay_line();
      logic [DW-1:0] e;
      for (int i = 0; i < 100 + DLY; i++) begin
         if (i < 100) begin
            bus.d_in = DW'(i);
            qd.push_back(DW'(i));
         end else begin
            bus.d_in = '0;
         end
         tick();
         if (i >= DLY - 1 && qd.size() > 0) begin
            e = qd.pop_front();
            n_cmp++;
            if (bus.d_out !== e) begin
               n_err++;
               $display("FAIL delay_line[%0d]: got %h want %h", i - DLY + 1, bus.d_out, e);
            end
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ram_a_fill();
      test_ram_b_dual();
      test_ram_b_collision();
      test_read_during_write();
      test_write_in_reset();
      test_reset_flush();
      test_delay_line();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/buffer_ram_tfsize.md
Name: buffer_ram_tfsize

Overview:
- Memory/alignment subsystem for the FHE (I)NTT datapath, in one block with three independent port groups:
  - 1R1W twiddle RAM (A), used for W / WQ storage.
  - 2R2W coefficient RAM (B), the butterfly operand store.
  - Fixed-latency delay line (D), which carries write addresses and enables alongside the butterfly pipeline.
- All groups share clk/rstn and have fixed, parameterised latencies so the controller can schedule statically.

Parameters:
- FSIZE, 64: data word width of both RAMs.
- DEPTH, 4096: words per RAM. Must be a power of two; AW = clog2(DEPTH).
- READ_LATENCY, 1: cycles from read address to read data, both RAMs (>=1).
- DLY_WIDTH, 12: delay-line data width.
- DLY_CYCLES, 8: delay-line latency in cycles (>=1).
- ID, 0: instance tag, simulation/debug only, no functional effect.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- a_raddr  in  AW  RAM A read address.
- a_rdata  out  FSIZE  RAM A read data.
- a_waddr  in  AW  RAM A write address.
- a_wdata  in  FSIZE  RAM A write data.
- a_wren  in  1  RAM A write enable.
- b_raddr0  in  AW  RAM B read address, port 0.
- b_raddr1  in  AW  RAM B read address, port 1.
- b_rdata0  out  FSIZE  RAM B read data, port 0.
- b_rdata1  out  FSIZE  RAM B read data, port 1.
- b_waddr0  in  AW  RAM B write address, port 0.
- b_wdata0  in  FSIZE  RAM B write data, port 0.
- b_wren0  in  1  RAM B write enable, port 0.
- b_waddr1  in  AW  RAM B write address, port 1.
- b_wdata1  in  FSIZE  RAM B write data, port 1.
- b_wren1  in  1  RAM B write enable, port 1.
- d_in  in  DLY_WIDTH  delay-line input.
- d_out  out  DLY_WIDTH  delay-line output.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - a_rdata, b_rdata0, b_rdata1, d_out and every internal read/delay pipeline stage go to 0.
  - RAM contents are NOT cleared; they retain prior values.
  - Writes presented while rstn=0 are ignored.
- Reads:
  - Every read port reads unconditionally every cycle; there is no read enable.
  - rdata at cycle t+READ_LATENCY = mem[raddr sampled at cycle t].
  - The read pipeline is fully pipelined: a new address is accepted each cycle.
- Writes:
  - With wren=1 at a rising edge, mem[waddr] <= wdata.
  - The write is visible to a read address presented on the following cycle or later.
- Read-during-write to the same address in the same cycle: read-first. The read returns the old contents.
- RAM B dual write, same address, same cycle: port 1 wins; port 0's data is discarded.
- RAM B dual write, different addresses: both writes complete.
- RAM B read ports 0 and 1 may target the same or different addresses with no restriction.
- Addresses are AW bits wide. Wrap-around is inherent; there is no out-of-range condition.
- Delay line:
  - Shift register of DLY_CYCLES stages, clocked every cycle with no enable.
  - d_out at cycle t+DLY_CYCLES = d_in at cycle t.
  - After reset, d_out is 0 until the first post-reset input has propagated through.
- Reset mid-operation:
  - In-flight read data and delay-line contents are flushed to 0.
  - The first valid outputs appear READ_LATENCY / DLY_CYCLES cycles after rstn returns high with new inputs.
- No handshakes, stalls or backpressure anywhere. Outputs are registered.

Test Plan:
- Reset flush: run the delay line with d_in=0xABC for 20 cycles, pulse rstn=0 for 1 cycle -> d_out=0 for the next DLY_CYCLES cycles, then 0xABC.
- RAM A fill/readback:
  - Stimulus: write a_wdata=addr*3+1 for addr 0..DEPTH-1, then read addr 0..DEPTH-1 back-to-back.
  - Required: a_rdata = addr*3+1, appearing exactly READ_LATENCY cycles after each address.
- RAM B dual-port:
  - Stimulus: write port0 addr 5=0x11 and port1 addr 9=0x22 in the same cycle, then read raddr0=9, raddr1=5.
  - Required: rdata0=0x22, rdata1=0x11.
- RAM B write collision: write port0 and port1 both to addr 7 (0xAA, 0xBB) in the same cycle -> a later read of 7 returns 0xBB.
- Read-during-write:
  - Stimulus: mem[3]=0x5. In one cycle, write 0x6 to addr 3 and read addr 3; read addr 3 again on the next cycle.
  - Required: first read 0x5, second read 0x6.
- Delay-line latency/throughput: drive d_in=cycle index 0..99 with DLY_CYCLES=8 -> d_out=k at cycle k+8, with no gaps or duplicates.
